// File: rtl/p09_vga_timing_if.sv
// Output bundle of the VGA timing generator: signed positions, syncs, blanking, frame pulse, time.
// master = timing generator, slave = colour stages consuming the timing.
interface p09_vga_timing_if #(
    parameter int HW = 11,
    parameter int VW = 11
);
    logic signed [HW-1:0] counter_h;
    logic signed [VW-1:0] counter_v;
    logic                 hsync;
    logic                 vsync;
    logic                 display_on;
    logic                 frame_start;
    logic [7:0]           cur_time;

    modport master (
        output counter_h, counter_v, hsync, vsync, display_on, frame_start, cur_time
    );

    modport slave (
        input counter_h, counter_v, hsync, vsync, display_on, frame_start, cur_time
    );
endinterface

// File: rtl/p09_vga_timing.sv
// VGA pixel-position/sync generator with a per-frame 8-bit animation time.
// Optional P09_TIME_PAUSE_EN adds a time_pause input that freezes cur_time at frame wrap.
module p09_vga_timing #(
    parameter int HACTIVE   = 640,
    parameter int HFRONT    = 16,
    parameter int HSYNC     = 96,
    parameter int HBACK     = 48,
    parameter int VACTIVE   = 480,
    parameter int VFRONT    = 10,
    parameter int VSYNC     = 2,
    parameter int VBACK     = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
`ifdef P09_TIME_PAUSE_EN
    input  logic             time_pause,
`endif
    p09_vga_timing_if.master bus
);
    localparam int HTOTAL  = HACTIVE + HFRONT + HSYNC + HBACK;
    localparam int VTOTAL  = VACTIVE + VFRONT + VSYNC + VBACK;
    localparam int HW      = $clog2(HTOTAL) + 1;
    localparam int VW      = $clog2(VTOTAL) + 1;
    localparam int H_START = -(HFRONT + HSYNC + HBACK);
    localparam int V_START = -(VFRONT + VSYNC + VBACK);

    localparam logic signed [HW-1:0] H_FIRST = HW'(H_START);
    localparam logic signed [HW-1:0] H_LAST  = HW'(HACTIVE - 1);
    localparam logic signed [HW-1:0] HS_BEG  = HW'(H_START + HFRONT);
    localparam logic signed [HW-1:0] HS_END  = HW'(H_START + HFRONT + HSYNC - 1);
    localparam logic signed [VW-1:0] V_FIRST = VW'(V_START);
    localparam logic signed [VW-1:0] V_LAST  = VW'(VACTIVE - 1);
    localparam logic signed [VW-1:0] VS_BEG  = VW'(V_START + VFRONT);
    localparam logic signed [VW-1:0] VS_END  = VW'(V_START + VFRONT + VSYNC - 1);

    logic signed [HW-1:0] h_q, h_d;
    logic signed [VW-1:0] v_q, v_d;
    logic                 hsync_q, hsync_d;
    logic                 vsync_q, vsync_d;
    logic                 display_on_q, display_on_d;
    logic                 frame_start_q, frame_start_d;
    logic [7:0]           cur_time_q, cur_time_d;
    logic                 line_wrap, frame_wrap, time_inc;

    always_comb begin
        line_wrap  = pix_en && (h_q == H_LAST);
        frame_wrap = line_wrap && (v_q == V_LAST);

        h_d = h_q;
        if (pix_en) h_d = line_wrap ? H_FIRST : h_q + HW'(1);
        v_d = v_q;
        if (line_wrap) v_d = frame_wrap ? V_FIRST : v_q + VW'(1);

        // Decode from the next counters so syncs/blanking line up with the registered position.
        hsync_d      = ((h_d >= HS_BEG) && (h_d <= HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d      = ((v_d >= VS_BEG) && (v_d <= VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        display_on_d = ~h_d[HW-1] & ~v_d[VW-1];

        frame_start_d = frame_wrap;
`ifdef P09_TIME_PAUSE_EN
        time_inc = frame_wrap && !time_pause;
`else
        time_inc = frame_wrap;
`endif
        cur_time_d = time_inc ? cur_time_q + 8'd1 : cur_time_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q           <= H_FIRST;
            v_q           <= V_FIRST;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            display_on_q  <= 1'b0;
            frame_start_q <= 1'b0;
            cur_time_q    <= 8'd0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
            frame_start_q <= frame_start_d;
            cur_time_q    <= cur_time_d;
        end
    end

    assign bus.counter_h   = h_q;
    assign bus.counter_v   = v_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.display_on  = display_on_q;
    assign bus.frame_start = frame_start_q;
    assign bus.cur_time    = cur_time_q;
endmodule
